// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA datapath: bus width and pre-scaler FSM states.
package rsa_pkg;

    localparam int RSA_W = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } rsa_pre_state_t;

endpackage

// File: rtl/rsa_mod_dbl.sv
// Modular doubling c_o = 2*c_i mod n_i for c_i < n_i; combinational, no backpressure.
module rsa_mod_dbl #(
    parameter int W = 256
) (
    input  logic [W-1:0] c_i,
    input  logic [W-1:0] n_i,
    output logic [W-1:0] c_o
);

    logic [W:0] d;
    logic [W:0] n_ext;
    logic [W:0] diff;

    // d < 2N, so a single conditional subtract fully reduces it.
    assign d     = {c_i, 1'b0};
    assign n_ext = {1'b0, n_i};
    assign diff  = d - n_ext;
    assign c_o   = (d >= n_ext) ? diff[W-1:0] : d[W-1:0];

endmodule

// File: rtl/rsa_mont_pre.sv
// Montgomery pre-scaler y = x * 2^K mod N, bit-serial; K cycles (K+1 with RSA_PRE_REDUCE_EN).
// Valid/ready on both sides; result held in DONE until out_ready, no new accept until IDLE.
module rsa_mont_pre
    import rsa_pkg::*;
#(
    parameter int W = RSA_W,
    parameter int K = 256
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] n_i,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] y_o,
    output logic         err_o,
    output logic         busy
);

    localparam int            CW   = $clog2(K + 1);
    localparam logic [CW-1:0] LAST = CW'(K - 1);

    rsa_pre_state_t state;
    logic [W-1:0]   c;
    logic [W-1:0]   nreg;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   c_dbl;

    rsa_mod_dbl #(.W(W)) u_dbl (
        .c_i (c),
        .n_i (nreg),
        .c_o (c_dbl)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            err_o     <= 1'b0;
            y_o       <= '0;
            c         <= '0;
            nreg      <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        nreg     <= n_i;
                        c        <= x_i;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        // Even modulus (including zero) has no Montgomery inverse.
                        if (!n_i[0]) begin
                            state     <= DONE;
                            err_o     <= 1'b1;
                            y_o       <= '0;
                            out_valid <= 1'b1;
                        end else begin
                            err_o <= 1'b0;
                            busy  <= 1'b1;
`ifdef RSA_PRE_REDUCE_EN
                            state <= PRE;
`else
                            state <= RUN;
`endif
                        end
                    end
                end
`ifdef RSA_PRE_REDUCE_EN
                PRE: begin
                    // Bring x < 2N down to x < N before doubling starts.
                    if (c >= nreg) begin
                        c <= c - nreg;
                    end
                    state <= RUN;
                end
`endif
                RUN: begin
                    c   <= c_dbl;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        y_o       <= c_dbl;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_mont_pre.sv
// Bench for rsa_mont_pre: an 8-bit/K=8 instance and a default 256-bit instance against arithmetic models.
module tb_rsa_mont_pre;

`ifdef RSA_PRE_REDUCE_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_s, s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_err, s_busy;
    logic [7:0]  s_x, s_n, s_y;
    logic        rst_l, l_in_valid, l_in_ready, l_out_valid, l_out_ready, l_err, l_busy;
    logic [255:0] l_x, l_n, l_y;

    int checks = 0;
    int errors = 0;

    rsa_mont_pre #(.W(8), .K(8)) dut_s (
        .clk(clk), .reset(rst_s), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .x_i(s_x), .n_i(s_n), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .y_o(s_y), .err_o(s_err), .busy(s_busy)
    );

    rsa_mont_pre dut_l (
        .clk(clk), .reset(rst_l), .in_valid(l_in_valid), .in_ready(l_in_ready),
        .x_i(l_x), .n_i(l_n), .out_valid(l_out_valid), .out_ready(l_out_ready),
        .y_o(l_y), .err_o(l_err), .busy(l_busy)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // x * 2^8 mod n with plain integer arithmetic
    function automatic logic [7:0] ref_s(input int x, input int n);
        return 8'((x * 256) % n);
    endfunction

    // x * 2^256 mod n with wide arithmetic
    function automatic logic [255:0] ref_l(input logic [255:0] x, input logic [255:0] n);
        logic [767:0] p;
        p = {512'b0, x} << 256;
        return 256'(p % {512'b0, n});
    endfunction

    task automatic op_s(input logic [7:0] x, input logic [7:0] n, input logic [7:0] exp_y,
                        input logic exp_e, input int exp_lat, input string tag);
        int g;
        int lat;
        @(negedge clk);
        s_x = x; s_n = n; s_in_valid = 1'b1;
        g = 0;
        while (!s_in_ready && g < 50) begin @(negedge clk); g++; end
        check({tag, "_acc_rdy"}, 256'(s_in_ready), 256'(1));
        @(posedge clk);
        #1 s_in_valid = 1'b0; s_x = 8'($urandom);
        @(negedge clk);
        check({tag, "_busy"}, 256'(s_busy), 256'(!exp_e));
        check({tag, "_in_rdy_low"}, 256'(s_in_ready), 256'(0));
        lat = 0;
        while (!s_out_valid && lat < 300) begin @(negedge clk); lat++; end
        check({tag, "_lat"}, 256'(lat), 256'(exp_lat));
        check({tag, "_y"}, 256'(s_y), 256'(exp_y));
        check({tag, "_err"}, 256'(s_err), 256'(exp_e));
        @(negedge clk);
        check({tag, "_ov_drop"}, 256'(s_out_valid), 256'(0));
        check({tag, "_in_rdy_back"}, 256'(s_in_ready), 256'(1));
    endtask

    task automatic start_l(input logic [255:0] x, input logic [255:0] n);
        int g;
        @(negedge clk);
        l_x = x; l_n = n; l_in_valid = 1'b1;
        g = 0;
        while (!l_in_ready && g < 50) begin @(negedge clk); g++; end
        check("l_acc_rdy", 256'(l_in_ready), 256'(1));
        @(posedge clk);
        #1 l_in_valid = 1'b0;
    endtask

    task automatic wait_l(output int lat);
        @(negedge clk);
        lat = 0;
        while (!l_out_valid && lat < 1000) begin @(negedge clk); lat++; end
    endtask

    initial begin
        logic [7:0]   xs, ns;
        logic [255:0] xl, nl, held;
        int lat;
        int xmax;

        rst_s = 1'b1; rst_l = 1'b1;
        s_in_valid = 1'b0; s_x = '0; s_n = '0; s_out_ready = 1'b1;
        l_in_valid = 1'b0; l_x = '0; l_n = '0; l_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 256'(s_in_ready), 256'(1));
        check("rst_out_valid", 256'(s_out_valid), 256'(0));
        check("rst_busy", 256'(s_busy), 256'(0));
        check("rst_err", 256'(s_err), 256'(0));
        check("rst_y", 256'(s_y), 256'(0));
        check("rst_l_in_ready", 256'(l_in_ready), 256'(1));
        rst_s = 1'b0; rst_l = 1'b0;

        // Directed small cases
        op_s(8'd1, 8'd13, 8'd9, 1'b0, 8 + EXTRA, "s_x1");
        op_s(8'd5, 8'd13, 8'd6, 1'b0, 8 + EXTRA, "s_x5");
        op_s(8'd0, 8'd13, 8'd0, 1'b0, 8 + EXTRA, "s_x0");
`ifdef RSA_PRE_REDUCE_EN
        op_s(8'd20, 8'd13, 8'd11, 1'b0, 9, "s_pre20");
`else
        op_s(8'd7, 8'd13, 8'd11, 1'b0, 8, "s_x7");
`endif
        op_s(8'd3, 8'd12, 8'd0, 1'b1, 0, "s_even");
        op_s(8'd3, 8'd0, 8'd0, 1'b1, 0, "s_zero");
        op_s(8'd254, 8'd255, ref_s(254, 255), 1'b0, 8 + EXTRA, "s_max");

        // Randomised small operands, back to back
        for (int i = 0; i < 8; i++) begin
            ns = 8'($urandom_range(1, 127) * 2 + 1);
            xmax = (EXTRA != 0) ? 2 * int'(ns) - 1 : int'(ns) - 1;
            if (xmax > 255) xmax = 255;
            xs = 8'($urandom_range(0, xmax));
            op_s(xs, ns, ref_s(int'(xs), int'(ns)), 1'b0, 8 + EXTRA, "s_rand");
        end

        // Large golden case with output stall
        nl = 256'd1 << 255; nl[0] = 1'b1;
        start_l(256'd3, nl);
        wait_l(lat);
        check("l_lat", 256'(lat), 256'(256 + EXTRA));
        check("l_y", l_y, ref_l(256'd3, nl));
        check("l_err", 256'(l_err), 256'(0));
        held = l_y;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("l_hold_y", l_y, held);
            check("l_hold_ov", 256'(l_out_valid), 256'(1));
            check("l_hold_ir", 256'(l_in_ready), 256'(0));
        end
        l_out_ready = 1'b1;
        @(negedge clk);
        check("l_ov_drop", 256'(l_out_valid), 256'(0));
        check("l_ir_back", 256'(l_in_ready), 256'(1));

        // Reset in the middle of an iteration run
        nl = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        nl[255] = 1'b1; nl[0] = 1'b1;
        xl = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom} % nl;
        start_l(xl, nl);
        repeat (100 + EXTRA) @(posedge clk);
        @(negedge clk);
        check("l_mid_busy", 256'(l_busy), 256'(1));
        rst_l = 1'b1;
        @(negedge clk);
        check("l_rst_busy", 256'(l_busy), 256'(0));
        check("l_rst_ir", 256'(l_in_ready), 256'(1));
        check("l_rst_ov", 256'(l_out_valid), 256'(0));
        check("l_rst_y", l_y, 256'(0));
        rst_l = 1'b0;

        // Fresh random large operands after reset
        for (int i = 0; i < 2; i++) begin
            nl = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            nl[0] = 1'b1;
            if (nl < 256'd3) nl = 256'd3;
            xl = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom} % nl;
            start_l(xl, nl);
            wait_l(lat);
            check("l_rand_lat", 256'(lat), 256'(256 + EXTRA));
            check("l_rand_y", l_y, ref_l(xl, nl));
            check("l_rand_err", 256'(l_err), 256'(0));
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
